// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared command, carry-mode and FSM state types for the sequential ALU
package alu_seq_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUBTRACT = 2'd1, MULTIPLY = 2'd2, SEL_SPARE = 2'd3} sel_t;
  typedef enum logic {WITH_CARRY = 1'b0, NO_CARRY = 1'b1} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd2} alu_state_t;
endpackage

// File: rtl/alu_mult_iter.sv
// alu_mult_iter: iterative shift-add unsigned multiplier, one partial product per cycle over WIDTH cycles
module alu_mult_iter #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_N,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = busy && cnt == '0;
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      mplier <= multiplier;
      cnt    <= CNT_W'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      busy   <= cnt != '0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle add/subtract and iterative multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_N,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [WIDTH-1:0]   Op1,
  input  logic [WIDTH-1:0]   Op2,
  input  sel_t               Sel,
  input  logic               C_In,
  input  mode_t              Mode,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               Equal,
  output logic               Illegal
);
  alu_state_t state, next_state;
  logic armed, accept, mul_done;
  logic [2*WIDTH-1:0] a, b, cin, alu, product;
  assign accept = In_Valid && In_Ready;
  assign a = {{WIDTH{1'b0}}, Op1};
  assign b = {{WIDTH{1'b0}}, Op2};
  assign cin = {{(2*WIDTH-1){1'b0}}, Mode == WITH_CARRY && C_In};
  assign alu = Sel == ADD ? a + b + cin : Sel == SUBTRACT ? a - b - cin : '0;
  alu_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .Clock        (Clock),
    .Reset_N      (Reset_N),
    .start        (accept && Sel == MULTIPLY),
    .multiplicand (Op1),
    .multiplier   (Op2),
    .product      (product),
    .done         (mul_done)
  );
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
    end
  end
  always_comb begin
    next_state = state == IDLE ? (accept ? (Sel == MULTIPLY ? MULT : DONE) : IDLE)
               : state == MULT ? (mul_done ? DONE : MULT)
               : (Out_Ready ? IDLE : DONE);
  end
  always_comb begin
    In_Ready  = armed && state == IDLE;
    Out_Valid = state == DONE;
  end
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      Result  <= '0;
      Equal   <= 1'b0;
      Illegal <= 1'b0;
    end else if (accept) begin
      Result  <= alu;
      Equal   <= Op1 == Op2;
      Illegal <= !(Sel inside {ADD, SUBTRACT, MULTIPLY});
    end else if (state == MULT && mul_done) begin
      Result  <= product;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench with a queue-based transaction model checked every cycle
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int W = 4;
  typedef struct {logic [7:0] res; logic eq; logic ill; int lat; int acc;} exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, c_in = 0, out_valid, out_ready = 1, equal, illegal;
  logic [W-1:0] op1 = 0, op2 = 0;
  logic [2*W-1:0] result;
  sel_t sel = ADD;
  mode_t mode = NO_CARRY;
  logic iv8 = 0, ir8, ov8, eq8, il8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] r8;
  sel_t s8 = ADD;
  int checks = 0, failures = 0, cyc = 0;
  exp_t q[$];
  exp_t ce;
  bit seen = 0;
  logic armed_m;
  alu_seq #(.WIDTH(W)) dut4 (
    .Clock(clk), .Reset_N(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
    .Op1(op1), .Op2(op2), .Sel(sel), .C_In(c_in), .Mode(mode),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Result(result),
    .Equal(equal), .Illegal(illegal)
  );
  alu_seq #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset_N(rst_n), .In_Valid(iv8), .In_Ready(ir8),
    .Op1(a8), .Op2(b8), .Sel(s8), .C_In(1'b0), .Mode(NO_CARRY),
    .Out_Valid(ov8), .Out_Ready(1'b1), .Result(r8),
    .Equal(eq8), .Illegal(il8)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) armed_m <= rst_n ? 1'b1 : 1'b0;
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  function automatic exp_t model(int x, int y, sel_t s, logic c, mode_t m);
    exp_t e;
    int cc = (m == WITH_CARRY) ? int'(c) : 0;
    e.eq = x == y;
    e.ill = 0;
    e.lat = 1;
    e.acc = 0;
    if (s == ADD) e.res = 8'((x + y + cc) % 256);
    else if (s == SUBTRACT) e.res = 8'((x - y - cc + 512) % 256);
    else if (s == MULTIPLY) begin e.res = 8'(x * y); e.lat = W + 1; end
    else begin e.res = 0; e.ill = 1; end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_equal", 32'(equal), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(armed_m && q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
        else begin
          ce = q[0];
          chk("result", 32'(result), 32'(ce.res));
          chk("equal", 32'(equal), 32'(ce.eq));
          chk("illegal", 32'(illegal), 32'(ce.ill));
          if (!seen) chk("latency", cyc - ce.acc + 1, ce.lat);
          seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end else if (q.size() != 0 && cyc - q[0].acc + 1 >= q[0].lat)
        chk("valid_by_latency", 32'(out_valid), 1);
      if (in_valid && in_ready) begin
        ce = model(int'(op1), int'(op2), sel, c_in, mode);
        ce.acc = cyc + 1;
        q.push_back(ce);
      end
    end
  end
  task automatic send(int x, int y, sel_t s, logic c, mode_t m);
    bit got = 0;
    @(posedge clk) #1;
    in_valid = 1; op1 = W'(x); op2 = W'(y); sel = s; c_in = c; mode = m;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) chk("accept_timeout", 32'(in_ready), 1);
    @(posedge clk) #1;
    in_valid = 0;
  endtask
  task automatic expect_out(string n, logic [7:0] r, logic e, logic il, int lat);
    int k = 0;
    bit got = 0;
    while (k < 30 && !got) begin
      @(negedge clk);
      k++;
      got = out_valid;
    end
    chk({n, "_valid"}, 32'(out_valid), 1);
    chk({n, "_lat"}, k, lat);
    chk({n, "_res"}, 32'(result), 32'(r));
    chk({n, "_eq"}, 32'(equal), 32'(e));
    chk({n, "_ill"}, 32'(illegal), 32'(il));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bit got, saw;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_low", 32'(in_ready), 0);
    chk("reset_result", 32'(result), 0);
    rst_n = 1;
    @(posedge clk) #1;
    chk("ready_after_release", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
    send(9, 7, ADD, 1, WITH_CARRY);
    expect_out("add_carry", 8'h11, 0, 0, 1);
    send(15, 15, ADD, 1, WITH_CARRY);
    expect_out("add_max", 8'h1F, 1, 0, 1);
    send(2, 5, SUBTRACT, 1, NO_CARRY);
    expect_out("sub_wrap", 8'hFD, 0, 0, 1);
    send(2, 5, SUBTRACT, 1, WITH_CARRY);
    expect_out("sub_borrow", 8'hFC, 0, 0, 1);
    send(6, 6, SUBTRACT, 0, NO_CARRY);
    expect_out("sub_equal", 8'h00, 1, 0, 1);
    send(15, 15, MULTIPLY, 1, WITH_CARRY);
    expect_out("mul_max", 8'hE1, 1, 0, 5);
    send(13, 11, MULTIPLY, 0, NO_CARRY);
    expect_out("mul_13x11", 8'h8F, 0, 0, 5);
    send(0, 9, MULTIPLY, 0, NO_CARRY);
    expect_out("mul_zero", 8'h00, 0, 0, 5);
    send(3, 3, SEL_SPARE, 0, NO_CARRY);
    expect_out("illegal", 8'h00, 1, 1, 1);
    @(posedge clk) #1;
    out_ready = 0;
    send(5, 10, ADD, 0, NO_CARRY);
    expect_out("bp", 8'h0F, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      in_valid = 1; op1 = W'(i + 1); op2 = W'(7 - i); sel = (i % 2) ? MULTIPLY : SUBTRACT;
      @(negedge clk);
      chk("bp_hold_result", 32'(result), 32'h0F);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_equal", 32'(equal), 0);
      chk("bp_no_accept", 32'(in_ready), 0);
    end
    @(posedge clk) #1;
    out_ready = 1; op1 = 4; op2 = 4; sel = ADD; c_in = 0; mode = NO_CARRY;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    chk("bp_reaccept", 32'(got), 1);
    @(posedge clk) #1;
    in_valid = 0;
    expect_out("bp_next", 8'h08, 1, 0, 1);
    @(negedge clk);
    chk("single_accept", 32'(out_valid), 0);
    @(posedge clk) #1;
    iv8 = 1; a8 = 8'd255; b8 = 8'd255; s8 = MULTIPLY;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = ir8;
    end
    chk("w8_accept", 32'(got), 1);
    @(posedge clk) #1;
    iv8 = 0;
    k = 0;
    got = 0;
    while (k < 30 && !got) begin
      @(negedge clk);
      k++;
      got = ov8;
      if (!got) chk("w8_busy_ready", 32'(ir8), 0);
    end
    chk("w8_lat", k, 9);
    chk("w8_res", 32'(r8), 32'hFE01);
    chk("w8_eq", 32'(eq8), 1);
    send(15, 15, MULTIPLY, 0, NO_CARRY);
    @(posedge clk);
    @(posedge clk) #1;
    rst_n = 0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_equal", 32'(equal), 0);
    chk("abort_illegal", 32'(illegal), 0);
    chk("abort_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw |= out_valid;
    end
    chk("abort_no_valid", 32'(saw), 0);
    send(1, 14, ADD, 1, WITH_CARRY);
    expect_out("post_abort_add", 8'h10, 0, 0, 1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
